// File: rtl/tx_frame_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tx_frame_arbiter_if
// Purpose  : Request/grant and transmitter handshake bundle for tx_frame_arbiter.
// Revision : 1.0
// ============================================================================
interface tx_frame_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] req_segment_num;
    logic [8*NUM_REQ-1:0]  req_txid;
    logic [8*NUM_REQ-1:0]  req_aux;
    logic [NUM_REQ-1:0]    ack;
    logic                  busy;
    logic                  start_sending;
    logic [15:0]           segment_num_out;
    logic [7:0]            txid_out;
    logic [7:0]            aux_out;
    logic [IDW-1:0]        grant_id;
    logic                  timeout_err;

    // Sources and transmitter side
    modport master (
        output req, req_segment_num, req_txid, req_aux, busy,
        input  ack, start_sending, segment_num_out, txid_out, aux_out,
               grant_id, timeout_err
    );

    // Arbiter side
    modport slave (
        input  req, req_segment_num, req_txid, req_aux, busy,
        output ack, start_sending, segment_num_out, txid_out, aux_out,
               grant_id, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/tx_frame_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tx_frame_arbiter
// Purpose  : Round-robin (or fixed-priority with TX_ARB_STRICT_PRIO_EN) sharing
//            of one frame transmitter, with busy tracking and inter-frame gap.
// Revision : 1.0
// ============================================================================
module tx_frame_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDW          = 2,
    parameter int IFG_CYCLES   = 12,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  wire logic         clk125MHz,
    input  wire logic         RST,
    tx_frame_arbiter_if.slave arb
);
    localparam int MAXC = (BUSY_TIMEOUT > IFG_CYCLES) ? BUSY_TIMEOUT : IFG_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               start_q;
    logic [15:0]        seg_q;
    logic [7:0]         txid_q;
    logic [7:0]         aux_q;
    logic [IDW-1:0]     gid_q;
    logic               tmo_q;

    logic               sel_found;
    logic [IDW-1:0]     sel_idx;
    logic [NUM_REQ-1:0] ack_d;
    logic [15:0]        seg_d;
    logic [7:0]         txid_d;
    logic [7:0]         aux_d;

`ifdef TX_ARB_STRICT_PRIO_EN
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        // Descending scan so the lowest requesting index is written last and wins
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (((arb.req >> i) & NUM_REQ'(1)) != '0) begin
                sel_found = 1'b1;
                sel_idx   = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] last_q;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        // Descending distance from last grant: the nearest requester after last wins
        for (int k = NUM_REQ; k >= 1; k--) begin
            int j;
            j = (int'(last_q) + k) % NUM_REQ;
            if (((arb.req >> j) & NUM_REQ'(1)) != '0) begin
                sel_found = 1'b1;
                sel_idx   = IDW'(j);
            end
        end
    end
`endif

    always_comb begin
        ack_d  = '0;
        seg_d  = '0;
        txid_d = '0;
        aux_d  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == sel_idx) begin
                ack_d[i] = 1'b1;
                seg_d    = arb.req_segment_num[16*i +: 16];
                txid_d   = arb.req_txid[8*i +: 8];
                aux_d    = arb.req_aux[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk125MHz) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            seg_q   <= '0;
            txid_q  <= '0;
            aux_q   <= '0;
            gid_q   <= '0;
            tmo_q   <= 1'b0;
`ifndef TX_ARB_STRICT_PRIO_EN
            last_q  <= IDW'(NUM_REQ - 1);
`endif
        end else begin
            start_q <= 1'b0;
            ack_q   <= '0;
            tmo_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_found && !arb.busy) begin
                        start_q <= 1'b1;
                        ack_q   <= ack_d;
                        seg_q   <= seg_d;
                        txid_q  <= txid_d;
                        aux_q   <= aux_d;
                        gid_q   <= sel_idx;
`ifndef TX_ARB_STRICT_PRIO_EN
                        last_q  <= sel_idx;
`endif
                        cnt_q   <= '0;
                        state_q <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A busy rise in the timeout cycle still counts as a started frame
                    if (arb.busy) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q >= CW'(BUSY_TIMEOUT - 1)) begin
                        tmo_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= (IFG_CYCLES == 0) ? IDLE : GAP;
                    end
                end
                WAIT_DONE: begin
                    if (!arb.busy) begin
                        cnt_q   <= '0;
                        state_q <= (IFG_CYCLES == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q >= CW'(IFG_CYCLES - 1)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb.ack             = ack_q;
    assign arb.start_sending   = start_q;
    assign arb.segment_num_out = seg_q;
    assign arb.txid_out        = txid_q;
    assign arb.aux_out         = aux_q;
    assign arb.grant_id        = gid_q;
    assign arb.timeout_err     = tmo_q;
endmodule
`default_nettype wire

// File: tb/tb_tx_frame_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tx_frame_arbiter
// Purpose  : Scoreboard bench for tx_frame_arbiter (honours TX_ARB_STRICT_PRIO_EN).
// Revision : 1.0
// ============================================================================
module tb_tx_frame_arbiter;
    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;
    localparam int IFG     = 12;
    localparam int BT      = 1024;
`ifdef TX_ARB_STRICT_PRIO_EN
    localparam bit RR = 1'b0;
`else
    localparam bit RR = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    tx_frame_arbiter_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

    tx_frame_arbiter #(
        .NUM_REQ(NUM_REQ), .IDW(IDW), .IFG_CYCLES(IFG), .BUSY_TIMEOUT(BT)
    ) dut (
        .clk125MHz(clk),
        .RST      (rst),
        .arb      (bus)
    );

    typedef struct {
        int          id;
        logic [15:0] seg;
        logic [7:0]  txid;
        logic [7:0]  aux;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every start pulse is popped against the scoreboard
    always @(negedge clk) begin
        exp_t               e;
        logic [NUM_REQ-1:0] oh;
        if (!rst) begin
            if (bus.start_sending === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected: got grant_id=%0d ack=%b, none expected", bus.grant_id, bus.ack);
                end else begin
                    e  = sb.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    if (bus.ack !== oh || bus.grant_id !== IDW'(e.id) || bus.segment_num_out !== e.seg ||
                        bus.txid_out !== e.txid || bus.aux_out !== e.aux) begin
                        errors++;
                        $display("FAIL grant_data: got id=%0d ack=%b seg=%h txid=%h aux=%h, expected id=%0d ack=%b seg=%h txid=%h aux=%h",
                                 bus.grant_id, bus.ack, bus.segment_num_out, bus.txid_out, bus.aux_out,
                                 e.id, oh, e.seg, e.txid, e.aux);
                    end
                end
            end else if (bus.ack !== '0) begin
                checks++;
                errors++;
                $display("FAIL ack_without_start: got ack=%b, expected 0", bus.ack);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [15:0] s, input logic [7:0] t, input logic [7:0] a);
        bus.req_segment_num[16*i +: 16] = s;
        bus.req_txid[8*i +: 8]          = t;
        bus.req_aux[8*i +: 8]           = a;
    endtask

    task automatic expect_grant(input int i, input logic [15:0] s, input logic [7:0] t, input logic [7:0] a);
        exp_t e;
        e.id = i; e.seg = s; e.txid = t; e.aux = a;
        sb.push_back(e);
    endtask

    task automatic wait_start(output int c);
        c = -1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus.start_sending === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            checks++;
            errors++;
            $display("FAIL start_wait: got no start_sending within 2000 cycles, expected one");
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_start"}, 32'(bus.start_sending), 0);
        chk({tag, "_ack"},   32'(bus.ack), 0);
        chk({tag, "_seg"},   32'(bus.segment_num_out), 0);
        chk({tag, "_txid"},  32'(bus.txid_out), 0);
        chk({tag, "_aux"},   32'(bus.aux_out), 0);
        chk({tag, "_gid"},   32'(bus.grant_id), 0);
        chk({tag, "_tmo"},   32'(bus.timeout_err), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, s1, s2, t, lo, s, f, win, lose;
        bit seen;
        bus.req             = '0;
        bus.req_segment_num = '0;
        bus.req_txid        = '0;
        bus.req_aux         = '0;
        bus.busy            = 1'b0;
        rst                 = 1'b1;
        tick(3);
        @(negedge clk);
        chk_outputs_zero("reset");
        tick(1);
        rst = 1'b0;

        // Single request from source 2, transmitter never answers -> timeout
        set_src(2, 16'h0012, 8'h02, 8'h05);
        expect_grant(2, 16'h0012, 8'h02, 8'h05);
        bus.req = 4'b0100;
        t = cyc;
        wait_start(s0);
        chk("single_latency", 32'(s0 - t), 1);
        bus.req[2] = 1'b0;

        set_src(0, 16'h00AB, 8'h07, 8'h33);
        expect_grant(0, 16'h00AB, 8'h07, 8'h33);
        bus.req[0] = 1'b1;
        t = -1;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (bus.timeout_err === 1'b1) begin
                t = cyc;
                break;
            end
        end
        chk("timeout_delay", 32'(t - s0), BT);
        @(negedge clk);
        chk("timeout_pulse_width", 32'(bus.timeout_err), 0);
        wait_start(s1);
        chk("gap_after_timeout", 32'(s1 - t), IFG + 1);
        bus.req[0] = 1'b0;

        // Full handshake: busy 3 cycles after start for 100 cycles
        tick(3);
        bus.busy = 1'b1;
        set_src(1, 16'h0BCD, 8'h09, 8'h44);
        expect_grant(1, 16'h0BCD, 8'h09, 8'h44);
        bus.req[1] = 1'b1;
        tick(100);
        bus.busy = 1'b0;
        lo = cyc;
        wait_start(s2);
        checks++;
        if (s2 - lo < IFG + 1) begin
            errors++;
            $display("FAIL ifg_spacing: got %0d cycles, expected at least %0d", s2 - lo, IFG + 1);
        end
        bus.req[1] = 1'b0;

        // Fairness with all sources requesting continuously
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            set_src(i, 16'h1000 + 16'(i), 8'h10 + 8'(i), 8'h20 + 8'(i));
        for (int g = 0; g < 6; g++) begin
            int id;
            id = RR ? (g % NUM_REQ) : 0;
            expect_grant(id, 16'h1000 + 16'(id), 8'h10 + 8'(id), 8'h20 + 8'(id));
        end
        bus.req = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            wait_start(s);
            if (g == 5) bus.req = '0;
            tick(2);
            bus.busy = 1'b1;
            tick(50);
            bus.busy = 1'b0;
        end

        // Simultaneous req[1]/req[3] after last=1, loser withdraws
        win  = RR ? 3 : 1;
        lose = RR ? 1 : 3;
        set_src(1, 16'h0111, 8'h11, 8'h01);
        set_src(3, 16'h0333, 8'h33, 8'h03);
        if (win == 3) expect_grant(3, 16'h0333, 8'h33, 8'h03);
        else          expect_grant(1, 16'h0111, 8'h11, 8'h01);
        bus.req = 4'b1010;
        wait_start(s);
        bus.req = '0;
        tick(2);
        bus.busy = 1'b1;
        tick(10);
        bus.busy = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.ack[lose] === 1'b1) seen = 1'b1;
        end
        chk("withdraw_no_ack", 32'(seen), 0);

        // Reset while in WAIT_DONE with busy high
        tick(1);
        set_src(0, 16'h0C0C, 8'h0C, 8'hC0);
        expect_grant(0, 16'h0C0C, 8'h0C, 8'hC0);
        bus.req = 4'b0001;
        wait_start(s);
        bus.req = '0;
        tick(2);
        bus.busy = 1'b1;
        tick(5);
        set_src(2, 16'h2222, 8'h22, 8'h2F);
        bus.req[2] = 1'b1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midreset");
        expect_grant(2, 16'h2222, 8'h22, 8'h2F);
        tick(20);
        bus.busy = 1'b0;
        f = cyc;
        wait_start(s);
        chk("resume_latency", 32'(s - f), 1);
        bus.req = '0;

        tick(5);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Shares the single Ethernet frame transmitter between up to NUM_REQ frame sources, e.g. the video segment sequencer, an ARP/ping responder and a retransmit engine.
- Each source raises a request carrying segment_num/txid/aux metadata. The arbiter picks one source round-robin and forwards its metadata with a one-cycle start_sending pulse.
- It then tracks the transmitter busy line through the frame, plus an inter-frame gap, before granting again.
- It sits between the send-control sources and the frame-building transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDW, 2, width of grant index; must satisfy 2**IDW >= NUM_REQ.
- IFG_CYCLES, 12, idle clocks enforced after busy falls and before the next grant; 0 means no gap.
- BUSY_TIMEOUT, 1024, clocks allowed from start_sending until busy rises.

Ports:
- clk125MHz  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  level request per source; held until the matching ack.
- req_segment_num  in  16*NUM_REQ  segment number, source i at bits [16i+15:16i].
- req_txid  in  8*NUM_REQ  redundancy copy id per source.
- req_aux  in  8*NUM_REQ  aux/frame counter per source.
- ack  out  NUM_REQ  one-cycle pulse: request i accepted.
- busy  in  1  transmitter busy, high for the duration of a frame.
- start_sending  out  1  one-cycle start pulse to the transmitter.
- segment_num_out  out  16  granted segment number.
- txid_out  out  8  granted txid.
- aux_out  out  8  granted aux.
- grant_id  out  IDW  index of the last granted source.
- timeout_err  out  1  one-cycle pulse when busy fails to rise.

Behaviour:
- Reset values:
  - all outputs 0; txid_out is also 0.
  - state IDLE.
  - round-robin pointer last = NUM_REQ-1, so source 0 has first priority.
  - all counters 0.
- States: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - If req != 0 and busy == 0 in cycle t, select the first set req[i] searching from (last+1) mod NUM_REQ upward with wrap.
  - In cycle t+1 (registered):
    - start_sending = 1 and ack[i] = 1;
    - segment_num_out, txid_out and aux_out carry source i's metadata as sampled at t;
    - grant_id = i and last = i;
    - state moves to WAIT_BUSY and the timeout counter clears.
  - If busy == 1 in IDLE (foreign or stuck transmitter), no grant is issued.
- Hold rule: start_sending and ack are high for exactly one cycle. Metadata outputs and grant_id hold until the next grant.
- WAIT_BUSY:
  - The counter increments every cycle.
  - busy == 1 → WAIT_DONE.
  - Counter reaching BUSY_TIMEOUT-1 with busy still 0 → timeout_err pulse for one cycle, then GAP (or IDLE if IFG_CYCLES == 0).
  - busy rising on the same cycle as the timeout takes priority over the timeout.
- WAIT_DONE: busy == 0 → GAP with the gap counter cleared (→ IDLE directly if IFG_CYCLES == 0).
- GAP: stays exactly IFG_CYCLES cycles, then IDLE.
- Minimum grant spacing: the earliest next start_sending is IFG_CYCLES+1 cycles after the cycle busy is first seen low in WAIT_DONE.
- Requester contract:
  - A source keeps req high and its metadata stable until ack.
  - A req still high after ack is treated as a new request, i.e. back-to-back frames from the same source.
  - req dropping before ack withdraws the request with no side effect.
- Round-robin fairness: with all NUM_REQ sources requesting continuously, grants cycle 0,1,2,…,NUM_REQ-1,0. No source waits more than NUM_REQ-1 grants.
- Counters are sized to hold max(BUSY_TIMEOUT, IFG_CYCLES) and never wrap within a state.
- RST mid-frame: everything returns to reset values the next cycle and any pending ack is lost. The transmitter is not aborted, so an active busy simply blocks IDLE until it falls.

Optional Feature:
- TX_ARB_STRICT_PRIO_EN:
  - Defined: round-robin is replaced by fixed priority, lowest index wins (source 0 = video path highest). The last pointer is unused; grant_id still reports the winner.
  - Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Single request: req=4'b0100 with segment 0x0012, txid 2, aux 0x05, busy held 0 → start_sending and ack[2] pulse one cycle later; outputs 0x0012/2/0x05; grant_id=2.
- Full handshake: grant, busy high 3 cycles later for 100 cycles then low → next grant no earlier than 13 cycles after busy low (IFG_CYCLES=12).
- Round-robin: req=4'b1111 held, busy modelled as 50-cycle frames → grant order 0,1,2,3,0,1. With TX_ARB_STRICT_PRIO_EN defined → 0,0,0,…
- Timeout: grant issued, busy never rises → timeout_err pulses exactly 1024 cycles after start_sending, then after the 12-cycle gap the next pending request is granted.
- Simultaneous and withdraw: req[1] and req[3] rise together after last=1 → source 3 granted first. req[1] dropped before its grant → no ack[1].
- Reset mid-frame: RST asserted in WAIT_DONE with busy=1 → outputs 0, state IDLE. No grant while busy stays 1; grant resumes one cycle after busy falls.
